vlc_ook_tx: RTL

- OOK/Manchester-free on-off-keyed frame transmitter for the VLC link; the transmit-side counterpart of the receiver's level/RSSI estimation path.
- Accepts payload bytes over a valid/ready stream and emits one 8-bit LED DAC sample per clk.
- Each frame is an alternating preamble, a start-of-frame byte, the payload MSB-first, then a low-level guard gap.
- The preamble and the programmable high/low levels give the receiver clean high/low averages for its level estimation.

---
 rtl/vlc_ook_tx_if.sv | 15 +
 rtl/vlc_ook_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlc_ook_tx_if.sv
// Payload byte stream between a frame source and the VLC OOK transmitter.
//   din   : payload byte
//   den   : din valid
//   dlast : din is the final byte of the frame
//   drdy  : transmitter can take a byte; transfer happens on den & drdy
// master = byte source, slave = transmitter.
interface vlc_ook_tx_if;
    logic [7:0] din;
    logic       den;
    logic       dlast;
    logic       drdy;

    modport master (output din, output den, output dlast, input drdy);
    modport slave  (input din, input den, input dlast, output drdy);
endinterface

// File: rtl/vlc_ook_tx.sv
// On-off-keyed VLC frame transmitter. Emits one LED DAC sample per clk:
// alternating preamble, start-of-frame byte, payload MSB-first, then a
// guard gap at the low level.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   strm     : payload byte stream (din/den/dlast/drdy), slave side
//   hlevel   : DAC code for a 1 bit (captured at frame start)
//   llevel   : DAC code for a 0 bit and for the gap (captured at frame start)
//   dout     : DAC sample
//   dout_en  : dout valid, high for every sample of a frame
//   bout     : current bit value
//   ben      : strobe on the first sample of each preamble/SFD/payload bit
//   busy     : frame in progress
//   err      : one-cycle pulse when the payload ran dry without dlast
// All outputs are registered; they are computed from the next-state values
// so they line up with the state they describe.
module vlc_ook_tx #(
    parameter int unsigned SPB      = 8,
    parameter int unsigned PRE_BITS = 16,
    parameter logic [7:0]  SFD      = 8'hA7,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    vlc_ook_tx_if.slave        strm,
    input  logic [7:0]         hlevel,
    input  logic [7:0]         llevel,
    output logic [7:0]         dout,
    output logic               dout_en,
    output logic               bout,
    output logic               ben,
    output logic               busy,
    output logic               err
);

    localparam int unsigned BIT_MAX =
        (PRE_BITS > GAP_BITS) ? ((PRE_BITS > 8) ? PRE_BITS : 8)
                              : ((GAP_BITS > 8) ? GAP_BITS : 8);
    localparam int unsigned BW = $clog2(BIT_MAX);

    localparam logic [7:0]    SAMP_LAST = 8'(SPB - 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_BITS - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_BITS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(7);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t        state_r,    state_s;
    logic [7:0]    samp_r,     samp_s;
    logic [BW-1:0] bit_r,      bit_s;
    logic [7:0]    shift_r,    shift_s;
    logic          cur_last_r, cur_last_s;
    logic [7:0]    buf_data_r, buf_data_s;
    logic          buf_last_r, buf_last_s;
    logic          buf_full_r, buf_full_s;
    logic [7:0]    hl_r,       hl_s;
    logic [7:0]    ll_r,       ll_s;
    logic [7:0]    dout_r,     dout_s;
    logic          dout_en_r,  dout_en_s;
    logic          bout_r,     bout_s;
    logic          ben_r,      ben_s;
    logic          busy_r,     busy_s;
    logic          err_r,      err_s;
    logic          drdy_r,     drdy_s;
    logic          accept_s;
    logic          samp_last_s;

    assign strm.drdy = drdy_r;
    assign dout      = dout_r;
    assign dout_en   = dout_en_r;
    assign bout      = bout_r;
    assign ben       = ben_r;
    assign busy      = busy_r;
    assign err       = err_r;

    // Next-state: holding buffer, frame sequencing and output decode
    always_comb begin
        state_s    = state_r;
        samp_s     = samp_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        cur_last_s = cur_last_r;
        buf_data_s = buf_data_r;
        buf_last_s = buf_last_r;
        buf_full_s = buf_full_r;
        hl_s       = hl_r;
        ll_s       = ll_r;
        err_s      = 1'b0;
        bout_s     = 1'b0;
        ben_s      = 1'b0;
        dout_s     = 8'd0;
        dout_en_s  = 1'b0;
        busy_s     = 1'b0;
        drdy_s     = 1'b0;

        accept_s    = strm.den & drdy_r;
        samp_last_s = (samp_r == SAMP_LAST);

        // drdy_r already encodes "buffer empty", so an accept never
        // collides with the boundary load below.
        if (accept_s) begin
            buf_full_s = 1'b1;
            buf_data_s = strm.din;
            buf_last_s = strm.dlast;
        end else begin
            buf_full_s = buf_full_r;
        end

        case (state_r)
            ST_IDLE: begin
                // A byte accepted on the last sample of a frame's final
                // byte is already buffered when we return here.
                if (accept_s || buf_full_r) begin
                    state_s = ST_PRE;
                    samp_s  = 8'd0;
                    bit_s   = BIT_ZERO;
                    hl_s    = hlevel;
                    ll_s    = llevel;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (samp_last_s) begin
                    samp_s = 8'd0;
                    if (bit_r == PRE_LAST) begin
                        state_s    = ST_SFD;
                        bit_s      = BIT_ZERO;
                        shift_s    = SFD;
                        cur_last_s = 1'b0;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    samp_s = samp_r + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                if (samp_last_s) begin
                    samp_s = 8'd0;
                    if (bit_r == BYTE_LAST) begin
                        bit_s = BIT_ZERO;
                        if (buf_full_r) begin
                            state_s    = ST_DATA;
                            shift_s    = buf_data_r;
                            cur_last_s = buf_last_r;
                            buf_full_s = 1'b0;
                        end else if (cur_last_r) begin
                            state_s = ST_GAP;
                        end else begin
                            // Underrun: the source missed the byte boundary.
                            state_s = ST_GAP;
                            err_s   = 1'b1;
                        end
                    end else begin
                        bit_s   = bit_r + BIT_ONE;
                        shift_s = {shift_r[6:0], 1'b0};
                    end
                end else begin
                    samp_s = samp_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (samp_last_s) begin
                    samp_s = 8'd0;
                    if (bit_r == GAP_LAST) begin
                        state_s = ST_IDLE;
                        bit_s   = BIT_ZERO;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    samp_s = samp_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                samp_s  = 8'd0;
                bit_s   = BIT_ZERO;
            end
        endcase

        // Output decode from the state about to be entered.
        case (state_s)
            ST_PRE:           bout_s = ~bit_s[0];
            ST_SFD, ST_DATA:  bout_s = shift_s[7];
            default:          bout_s = 1'b0;
        endcase

        if ((samp_s == 8'd0) &&
            ((state_s == ST_PRE) || (state_s == ST_SFD) || (state_s == ST_DATA))) begin
            ben_s = 1'b1;
        end else begin
            ben_s = 1'b0;
        end

        if (state_s != ST_IDLE) begin
            dout_en_s = 1'b1;
            busy_s    = 1'b1;
            dout_s    = bout_s ? hl_s : ll_s;
        end else begin
            dout_en_s = 1'b0;
            busy_s    = 1'b0;
            dout_s    = 8'd0;
        end

        drdy_s = ~buf_full_s & (state_s != ST_GAP);
    end

    // State, buffer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            samp_r     <= 8'd0;
            bit_r      <= BIT_ZERO;
            shift_r    <= 8'd0;
            cur_last_r <= 1'b0;
            buf_data_r <= 8'd0;
            buf_last_r <= 1'b0;
            buf_full_r <= 1'b0;
            hl_r       <= 8'd0;
            ll_r       <= 8'd0;
            dout_r     <= 8'd0;
            dout_en_r  <= 1'b0;
            bout_r     <= 1'b0;
            ben_r      <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            drdy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            samp_r     <= samp_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            cur_last_r <= cur_last_s;
            buf_data_r <= buf_data_s;
            buf_last_r <= buf_last_s;
            buf_full_r <= buf_full_s;
            hl_r       <= hl_s;
            ll_r       <= ll_s;
            dout_r     <= dout_s;
            dout_en_r  <= dout_en_s;
            bout_r     <= bout_s;
            ben_r      <= ben_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
            drdy_r     <= drdy_s;
        end
    end

endmodule
